// File: rtl/sram22_64x32m4w8_port_ctrl.sv
// Port controller between the host request/response channels and the
// 64x32 byte-masked SRAM22 macro. Requests drive the macro pins directly;
// read data comes back one cycle later and goes to the host either straight
// from the macro (bypass) or from a small response FIFO when the host stalls.
module sram22_64x32m4w8_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 4,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] rsp_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [CNT_W:0]        occ;
    logic                  fire;
    logic                  buf_empty;
    logic                  push;
    logic                  pop;

    // Circular pointer advance that wraps at the buffer depth
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check, macro pin drive and response selection. A read in flight
    // counts as an occupied slot so its data always has somewhere to land.
    always_comb begin
        occ        = {1'b0, count} + (CNT_W + 1)'(rd_pend);
        req_ready  = !rst && (occ < (CNT_W + 1)'(RESP_DEPTH));
        fire       = req_valid && req_ready;

        sram_we    = fire && req_we;
        sram_wmask = rst ? '0 : req_wmask;
        sram_din   = req_wdata;
        sram_addr  = fire ? req_addr : addr_q;

        buf_empty  = (count == '0);
        rsp_valid  = !rst && (!buf_empty || rd_pend);
        rsp_rdata  = buf_empty ? sram_dout : rsp_mem[rd_ptr];

        pop        = !rst && !buf_empty && rsp_ready;
        push       = !rst && rd_pend && !(buf_empty && rsp_ready);
    end

    // Control state: read-pending flag, held address, FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            addr_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            rd_pend <= fire && !req_we;
            if (fire) begin
                addr_q <= req_addr;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response storage; the macro output is captured here when it cannot bypass
    always_ff @(posedge clk) begin
        if (push) begin
            rsp_mem[wr_ptr] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram22_64x32m4w8_port_ctrl.sv
// Self-checking bench for the SRAM22 port controller: a behavioural macro
// model sits on the sram_* pins, a reference memory predicts read data and
// a queue of expected responses is compared as the host takes them.
module tb_sram22_64x32m4w8_port_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int          checks;
    int          failures;
    int          cycle;
    int          last_pop_cycle;
    int          max_gap;
    int          pop_count;
    int          waited;

    logic [31:0] macro_mem [64];
    logic [31:0] ref_mem   [64];
    logic [31:0] exp_q     [$];

    sram22_64x32m4w8_port_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter for response spacing
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural macro: masked write, otherwise re-read the address each edge
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[b]) macro_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end
            sram_dout <= 'x;
        end else begin
            sram_dout <= macro_mem[sram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Monitor: predict read data on accept, compare on each host take
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", rsp_rdata, 32'hxxxx_xxxx);
                end else begin
                    checkOutput("rsp_data", rsp_rdata, exp_q.pop_front());
                end
                if (last_pop_cycle >= 0 && (cycle - last_pop_cycle) > max_gap)
                    max_gap = cycle - last_pop_cycle;
                last_pop_cycle = cycle;
                pop_count++;
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    // Offer one request and hold it until accepted; leaves req_valid high
    task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, output int wait_cycles);
        logic accepted;
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = data;
        req_wmask   = mask;
        wait_cycles = 0;
        forever begin
            @(negedge clk);
            accepted = req_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
            wait_cycles++;
            if (wait_cycles > 50) begin
                checkOutput("req_timeout", 32'(wait_cycles), 32'd0);
                break;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        cycle          = 0;
        last_pop_cycle = -1;
        max_gap        = 0;
        pop_count      = 0;
        for (int i = 0; i < 64; i++) begin
            macro_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = 4'hF;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_sram_we", 32'(sram_we), 32'd0);
        checkOutput("rst_sram_wmask", 32'(sram_wmask), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: write then read with one-cycle bypass latency
        applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, waited);
        applyStimulus(1'b0, 6'd5, 32'h0, 4'h0, waited);
        req_valid = 1'b0;
        checkOutput("t1_latency_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t1_data", rsp_rdata, 32'hDEADBEEF);
        idleCycles(2);

        // 2: byte-masked partial write
        applyStimulus(1'b1, 6'd9, 32'h11223344, 4'hF, waited);
        applyStimulus(1'b1, 6'd9, 32'hAABBCCDD, 4'b0101, waited);
        applyStimulus(1'b0, 6'd9, 32'h0, 4'h0, waited);
        req_valid = 1'b0;
        checkOutput("t2_data", rsp_rdata, 32'h11BB33DD);
        idleCycles(2);

        // 3: backpressure fills the buffer and stops acceptance
        applyStimulus(1'b1, 6'd0, 32'hA0, 4'hF, waited);
        applyStimulus(1'b1, 6'd1, 32'hA1, 4'hF, waited);
        applyStimulus(1'b1, 6'd2, 32'hA2, 4'hF, waited);
        idleCycles(1);
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'h0, 4'h0, waited);
        applyStimulus(1'b0, 6'd1, 32'h0, 4'h0, waited);
        req_addr = 6'd2;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t3_ready_low", 32'(req_ready), 32'd0);
            checkOutput("t3_head_stable", rsp_rdata, 32'hA0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 6'd2, 32'h0, 4'h0, waited);
        checkOutput("t3_third_waited", 32'(waited), 32'd1);
        idleCycles(3);
        checkOutput("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // 4: back-to-back reads at full rate
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 6'(16 + i), 32'h5000 + 32'(i), 4'hF, waited);
        idleCycles(1);
        last_pop_cycle = -1;
        max_gap        = 0;
        pop_count      = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 6'(16 + i), 32'h0, 4'h0, waited);
            checkOutput("t4_no_stall", 32'(waited), 32'd0);
        end
        idleCycles(3);
        checkOutput("t4_count", 32'(pop_count), 32'd8);
        checkOutput("t4_gap", 32'(max_gap), 32'd1);

        // 5: write right after a read to the same address
        applyStimulus(1'b1, 6'd3, 32'h1, 4'hF, waited);
        idleCycles(1);
        pop_count = 0;
        applyStimulus(1'b0, 6'd3, 32'h0, 4'h0, waited);
        applyStimulus(1'b1, 6'd3, 32'h2, 4'hF, waited);
        applyStimulus(1'b0, 6'd3, 32'h0, 4'h0, waited);
        req_valid = 1'b0;
        checkOutput("t5_new_data", rsp_rdata, 32'h2);
        idleCycles(2);
        checkOutput("t5_count", 32'(pop_count), 32'd2);

        // 6: reset with responses buffered drops them
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'h0, 4'h0, waited);
        applyStimulus(1'b0, 6'd1, 32'h0, 4'h0, waited);
        idleCycles(1);
        checkOutput("t6_buffered_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6_valid_after_rst", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("t6_no_stale", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 6'd5, 32'h0, 4'h0, waited);
        req_valid = 1'b0;
        checkOutput("t6_read_after", rsp_rdata, 32'hDEADBEEF);
        idleCycles(3);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
